// File: rtl/mem_arb_pkg.sv
// Shared types for the memory access arbiter: FSM state encoding, default bus widths
// and the round-robin index wrap helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACCESS,
    S_RESP
  } arb_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Round-robin winner select: first set request bit at or above ptr, wrapping at NUM_REQ.
// Latency: combinational. Backpressure: none, pure function of i_req and i_ptr.
// Outputs zero when no request is set.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_win_oh,
  output logic [IDX_W-1:0]   o_win_idx
);

  logic w_found;

  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[rr_wrap(int'(i_ptr) + i, NUM_REQ)]) begin
        w_found = 1'b1;
        o_win_oh[rr_wrap(int'(i_ptr) + i, NUM_REQ)] = 1'b1;
        o_win_idx = IDX_W'(rr_wrap(int'(i_ptr) + i, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin share of the memory_controller port; latches winner's command, strobes around mem_busy.
// Latency: gnt+strobe 1 cycle after req, ack 1 cycle after last strobe cycle (3 cycles min per access).
// Backpressure: mem_busy stalls strobe start in ISSUE; MEM_ARB_TIMEOUT_EN bounds that wait with an err ack.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACCESS_LAT = 1
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_err,
  output logic                      o_mem_rd,
  output logic                      o_mem_wr,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  input  logic                      i_mem_error,
  input  logic                      i_mem_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAT_W = $clog2(ACCESS_LAT + 1);

  arb_state_t           r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_we;
  logic [LAT_W-1:0]     r_acc_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_err;
  logic                 r_mem_rd;
  logic                 r_mem_wr;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0]           r_to_cnt;
`endif

  logic [NUM_REQ-1:0]   w_win_oh;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_win_we;
  logic [NUM_REQ-1:0]   w_ack_oh;

  mem_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req     (i_req),
    .i_ptr     (r_ptr),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx)
  );

  assign w_win_we = i_req_we[w_win_idx];
  assign w_ack_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_we        <= 1'b0;
      r_acc_cnt   <= '0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_gnt <= '0;
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_idx       <= w_win_idx;
            r_we        <= w_win_we;
            r_mem_addr  <= i_req_addr[w_win_idx*ADDR_W +: ADDR_W];
            r_mem_wdata <= i_req_wdata[w_win_idx*DATA_W +: DATA_W];
            r_gnt       <= w_win_oh;
            r_acc_cnt   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
            // Flash idle at grant time: strobe together with gnt rather than spend a cycle in ISSUE.
            if (!i_mem_busy) begin
              r_mem_rd <= ~w_win_we;
              r_mem_wr <= w_win_we;
              r_state  <= S_ACCESS;
            end else begin
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!i_mem_busy) begin
            r_mem_rd  <= ~r_we;
            r_mem_wr  <= r_we;
            r_acc_cnt <= '0;
            r_state   <= S_ACCESS;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (r_to_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            r_ack   <= w_ack_oh;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= S_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
`endif
        end
        S_ACCESS: begin
          if (r_acc_cnt == LAT_W'(ACCESS_LAT - 1)) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_rdata  <= r_we ? '0 : i_mem_rdata;
            r_err    <= i_mem_error;
            r_ack    <= w_ack_oh;
            r_state  <= S_RESP;
          end else begin
            r_acc_cnt <= r_acc_cnt + LAT_W'(1);
          end
        end
        S_RESP: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_ptr   <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_ack       = r_ack;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign o_mem_rd    = r_mem_rd;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: vector table, hand sequences, random traffic against a round-robin model.
// Defining MEM_ARB_TIMEOUT_EN also builds the busy-timeout sequence.
module tb_mem_access_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 6;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_we, gnt, ack;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rdata, mem_rdata, mem_wdata;
  logic [AW-1:0]   mem_addr;
  logic            err, mem_rd, mem_wr, mem_error, mem_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .ACCESS_LAT (1)
`ifdef MEM_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_req (req), .i_req_we (req_we), .i_req_addr (req_addr), .i_req_wdata (req_wdata),
    .o_gnt (gnt), .o_ack (ack), .o_rdata (rdata), .o_err (err),
    .o_mem_rd (mem_rd), .o_mem_wr (mem_wr), .o_mem_addr (mem_addr), .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata), .i_mem_error (mem_error), .i_mem_busy (mem_busy)
  );

  // Memory stand-in: data derived from address, error region at 0xFFFF_xxxx.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_A5A5);
  endfunction
  function automatic logic bad_addr(input logic [31:0] a);
    return a[31:16] == 16'hFFFF;
  endfunction
  assign mem_rdata = mem_model(mem_addr);
  assign mem_error = bad_addr(mem_addr);

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: condition violated", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    mem_busy = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    int          r;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          busy;
    logic [N-1:0] exp_gnt;
    int          exp_strobe;
    int          exp_ack;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic run_vec(input int id, input vec_t v);
    int first_s = -1, ack_c = -1;
    logic [N-1:0] g1 = '0, ackv = '0;
    logic [31:0] rd = '0;
    logic e = 1'b0, extra = 1'b0, ovl = 1'b0, kind_bad = 1'b0, addr_bad = 1'b0, wd_bad = 1'b0;
    req_we[v.r] = v.we;
    req_addr[v.r*AW +: AW] = v.addr;
    req_wdata[v.r*DW +: DW] = v.wdata;
    req[v.r] = 1'b1;
    mem_busy = (v.busy > 0);
    for (int c = 1; c <= 40; c++) begin
      step();
      mem_busy = (c < v.busy);
      if (c == 1) g1 = gnt;
      else if (gnt != '0) extra = 1'b1;
      if ((mem_rd || mem_wr) && first_s < 0) begin
        first_s = c;
        kind_bad = (mem_wr !== v.we) || (mem_rd !== !v.we);
      end
      if (mem_rd && mem_wr) ovl = 1'b1;
      if (mem_addr !== v.addr) addr_bad = 1'b1;
      if (v.we && mem_wdata !== v.wdata) wd_bad = 1'b1;
      if (ack != '0) begin
        ack_c = c; ackv = ack; rd = rdata; e = err;
        break;
      end
    end
    req[v.r] = 1'b0;
    chk($sformatf("vec%0d gnt", id), 64'(g1), 64'(v.exp_gnt));
    chk($sformatf("vec%0d gnt_once", id), 64'(extra), 64'(0));
    chk($sformatf("vec%0d strobe_cycle", id), 64'(first_s), 64'(v.exp_strobe));
    chk($sformatf("vec%0d strobe_kind", id), 64'(kind_bad), 64'(0));
    chk($sformatf("vec%0d rd_wr_overlap", id), 64'(ovl), 64'(0));
    chk($sformatf("vec%0d addr_stable", id), 64'(addr_bad), 64'(0));
    chk($sformatf("vec%0d wdata_stable", id), 64'(wd_bad), 64'(0));
    chk($sformatf("vec%0d ack_cycle", id), 64'(ack_c), 64'(v.exp_ack));
    chk($sformatf("vec%0d ack", id), 64'(ackv), 64'(v.exp_gnt));
    chk($sformatf("vec%0d rdata", id), 64'(rd), 64'(v.exp_rdata));
    chk($sformatf("vec%0d err", id), 64'(e), 64'(v.exp_err));
    step();
  endtask

  task automatic wait_ack(input string nm, input int r, input logic [31:0] exp_rd, input logic exp_e);
    for (int c = 0; c < 30; c++) begin
      step();
      if (ack != '0) begin
        chk({nm, " ack"}, 64'(ack), 64'(1) << r);
        chk({nm, " rdata"}, 64'(rdata), 64'(exp_rd));
        chk({nm, " err"}, 64'(err), 64'(exp_e));
        req[r] = 1'b0;
        return;
      end
    end
    req[r] = 1'b0;
    fail({nm, " ack timeout"});
  endtask

  task automatic run_rr_burst();
    int ord[$];
    int aord[$];
    int exp_ord[4] = '{0, 1, 2, 0};
    logic relaunch = 1'b0, done0 = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_we[i] = 1'b0;
      req_addr[i*AW +: AW] = 32'h100 + 32'(4 * i);
    end
    req = '1;
    for (int c = 1; c <= 80 && aord.size() < 4; c++) begin
      step();
      if (relaunch) begin req[0] = 1'b1; relaunch = 1'b0; end
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) ord.push_back(i);
        if (ack[i]) begin
          aord.push_back(i);
          req[i] = 1'b0;
          if (i == 0 && !done0) begin done0 = 1'b1; relaunch = 1'b1; end
        end
      end
    end
    req = '0;
    chk("rr grant count", 64'(ord.size()), 64'(4));
    chk("rr ack count", 64'(aord.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < ord.size())  chk($sformatf("rr gnt order %0d", k), 64'(ord[k]), 64'(exp_ord[k]));
      if (k < aord.size()) chk($sformatf("rr ack order %0d", k), 64'(aord[k]), 64'(exp_ord[k]));
    end
    step();
  endtask

  task automatic run_random();
    int ptr_m = 0, outst = -1, raised = 0, acked = 0, busy_run = 0, w;
    int waits[N];
    logic [N-1:0] req_prev = '0, acked_mask;
    logic ovl = 1'b0;
    logic [31:0] a;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 1600; c++) begin
      step();
      if (mem_rd && mem_wr) ovl = 1'b1;
      acked_mask = '0;
      if (gnt != '0) begin
        w = pick(req_prev, ptr_m);
        chk("rnd gnt", 64'(gnt), (w < 0) ? 64'(0) : (64'(1) << w));
        if (outst >= 0) fail("rnd gnt while access outstanding");
        outst = w;
        for (int j = 0; j < N; j++) begin
          if (j != w && req_prev[j]) begin
            waits[j]++;
            if (waits[j] > N - 1) fail($sformatf("rnd fairness req%0d", j));
          end
        end
        if (w >= 0) waits[w] = 0;
      end
      if (ack != '0) begin
        if (outst < 0) fail("rnd ack without grant");
        else begin
          a = req_addr[outst*AW +: AW];
          chk("rnd ack", 64'(ack), 64'(1) << outst);
          chk("rnd rdata", 64'(rdata), req_we[outst] ? 64'(0) : 64'(mem_model(a)));
          chk("rnd err", 64'(err), 64'(bad_addr(a)));
          ptr_m = (outst + 1) % N;
          req[outst] = 1'b0;
          acked_mask[outst] = 1'b1;
          acked++;
          outst = -1;
        end
      end
      if (c < 1500) begin
        for (int i = 0; i < N; i++) begin
          if (!req[i] && !acked_mask[i] && $urandom_range(0, 3) == 0) begin
            req_we[i] = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? (32'hFFFF_0000 | 32'($urandom_range(0, 255))) :
                                   (32'h1000 + 32'($urandom_range(0, 255) * 4));
            req_wdata[i*DW +: DW] = $urandom;
            req[i] = 1'b1;
            raised++;
          end
        end
      end
      mem_busy = (busy_run >= 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
      busy_run = mem_busy ? busy_run + 1 : 0;
      req_prev = req;
    end
    chk("rnd drain", 64'(acked), 64'(raised));
    chk("rnd rd_wr overlap", 64'(ovl), 64'(0));
  endtask

  vec_t vt[5];

  initial begin
    logic no_ack;
    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; mem_busy = 1'b0;
    vt[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,          0, 3'b001, 1, 2, 32'hDEAD_BEEF, 1'b0};
    vt[1] = '{1, 1'b1, 32'h0000_0100, 32'h1234_5678,  5, 3'b010, 6, 7, 32'h0,         1'b0};
    vt[2] = '{2, 1'b0, 32'hFFFF_0000, 32'h0,          0, 3'b100, 1, 2, 32'hA5A5_A5A5, 1'b1};
    vt[3] = '{0, 1'b0, 32'h0000_0020, 32'h0,          2, 3'b001, 3, 4, 32'h5A5A_A585, 1'b0};
    vt[4] = '{1, 1'b1, 32'hFFFF_0004, 32'hCAFE_F00D,  1, 3'b010, 2, 3, 32'h0,         1'b1};

    step();
    step();
    chk("reset ctrl", 64'({gnt, ack, err, mem_rd, mem_wr}), 64'(0));
    chk("reset rdata/addr", {rdata, mem_addr}, 64'(0));
    chk("reset wdata", 64'(mem_wdata), 64'(0));
    rst_n = 1'b1;
    step();

    run_rr_burst();
    for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

    // Abort a read from requester 2 mid-strobe; pointer must return to 0.
    req_we[2] = 1'b0;
    req_addr[2*AW +: AW] = 32'h30;
    req[2] = 1'b1;
    step();
    chk("rst mid strobe", 64'(mem_rd), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst abort outputs", 64'({gnt, ack, mem_rd, mem_wr}), 64'(0));
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    no_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (ack != '0) no_ack = 1'b0;
    end
    chk("rst no ack after abort", 64'(no_ack), 64'(1));
    req_we = '0;
    req_addr[0*AW +: AW] = 32'h40;
    req_addr[2*AW +: AW] = 32'h50;
    req = 3'b101;
    step();
    chk("rst ptr gnt", 64'(gnt), 64'(3'b001));
    wait_ack("rst req0", 0, mem_model(32'h40), 1'b0);
    wait_ack("rst req2", 2, mem_model(32'h50), 1'b0);
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int ack_c = -1;
      logic strobed = 1'b0;
      logic [31:0] rd = '1;
      logic e = 1'b0;
      req_we[0] = 1'b0;
      req_addr[0*AW +: AW] = 32'h60;
      mem_busy = 1'b1;
      req[0] = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        step();
        if (mem_rd || mem_wr) strobed = 1'b1;
        if (ack != '0) begin ack_c = c; rd = rdata; e = err; break; end
      end
      req[0] = 1'b0;
      mem_busy = 1'b0;
      chk("timeout ack cycle", 64'(ack_c), 64'(1 + TO));
      chk("timeout no strobe", 64'(strobed), 64'(0));
      chk("timeout err", 64'(e), 64'(1));
      chk("timeout rdata", 64'(rd), 64'(0));
      step();
    end
`endif

    do_reset();
    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
